line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_ctrl.sv
// Line-buffer controller for a 3x1 vertical window over a raster pixel stream.
// Two external FWFT FIFOs hold the previous two lines; one column is emitted per pixel from row 2 on.
module line_buf_ctrl #(
   parameter int WIDTH = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic                       s_valid,
   input  logic [WIDTH-1:0]           s_data,
   output logic                       s_ready,

   output logic                       f0_wr_en,
   output logic [WIDTH-1:0]           f0_din,
   output logic                       f0_rd_en,
   input  logic [WIDTH-1:0]           f0_dout,
   input  logic                       f0_empty,
   input  logic                       f0_full,

   output logic                       f1_wr_en,
   output logic [WIDTH-1:0]           f1_din,
   output logic                       f1_rd_en,
   input  logic [WIDTH-1:0]           f1_dout,
   input  logic                       f1_empty,
   input  logic                       f1_full,

   output logic [WIDTH-1:0]           col_top,
   output logic [WIDTH-1:0]           col_mid,
   output logic [WIDTH-1:0]           col_bot,
   output logic                       col_valid,
   output logic [$clog2(IMG_W)-1:0]   col_x,
   output logic [$clog2(IMG_H)-1:0]   row_y,
   output logic                       frame_done
);

   localparam int CXW = $clog2(IMG_W);
   localparam int RYW = $clog2(IMG_H);

   localparam logic [CXW-1:0] CX_LAST = CXW'(IMG_W - 1);
   localparam logic [RYW-1:0] RY_LAST = RYW'(IMG_H - 1);

   localparam logic [1:0] ST_FILL0 = 2'd0;
   localparam logic [1:0] ST_FILL1 = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CXW-1:0]   cx_q, cx_d;
   logic [RYW-1:0]   ry_q, ry_d;
   logic [WIDTH-1:0] col_top_q, col_top_d;
   logic [WIDTH-1:0] col_mid_q, col_mid_d;
   logic [WIDTH-1:0] col_bot_q, col_bot_d;
   logic [CXW-1:0]   col_x_q, col_x_d;
   logic [RYW-1:0]   row_y_q, row_y_d;
   logic             col_valid_q, col_valid_d;
   logic             frame_done_q, frame_done_d;

   logic             accept;
   logic             last_col;
   logic             last_row;
   logic             in_fill1_run;
   logic             in_run;
   logic             in_flush;
   logic [CXW-1:0]   cx_next;
   logic [RYW-1:0]   ry_next;

   // Handshake: rows 1+ need line y-1 waiting in f0, rows 2+ also need line y-2 in f1.
   always_comb begin
      in_fill1_run = (state_q == ST_FILL1) || (state_q == ST_RUN);
      in_run       = (state_q == ST_RUN);
      in_flush     = (state_q == ST_FLUSH);
      s_ready      = rst
                     & ~in_flush
                     & ~f0_full
                     & ((ry_q == '0) | ~f0_empty)
                     & ((ry_q < RYW'(2)) | (~f1_empty & ~f1_full));
      accept       = s_valid & s_ready;
      last_col     = (cx_q == CX_LAST);
      last_row     = (ry_q == RY_LAST);
      cx_next      = last_col ? '0 : cx_q + CXW'(1);
      ry_next      = last_col ? ry_q + RYW'(1) : ry_q;
   end

   // FIFO strobes: every accepted pixel is pushed into f0 while f0's head shifts down into f1.
   always_comb begin
      f0_din   = s_data;
      f1_din   = f0_dout;
      f0_wr_en = accept;
      f1_wr_en = accept & in_fill1_run;
      f0_rd_en = (accept & in_fill1_run) | (rst & in_flush & ~f0_empty);
      f1_rd_en = (accept & in_run)       | (rst & in_flush & ~f1_empty);
   end

   always_comb begin
      state_d      = state_q;
      cx_d         = cx_q;
      ry_d         = ry_q;
      col_top_d    = col_top_q;
      col_mid_d    = col_mid_q;
      col_bot_d    = col_bot_q;
      col_x_d      = col_x_q;
      row_y_d      = row_y_q;
      col_valid_d  = 1'b0;
      frame_done_d = 1'b0;

      case (state_q)
         ST_FILL0: begin
            if (accept) begin
               cx_d = cx_next;
               ry_d = ry_next;
               if (last_col) begin
                  state_d = ST_FILL1;
               end
            end
         end

         ST_FILL1: begin
            if (accept) begin
               cx_d = cx_next;
               ry_d = ry_next;
               if (last_col) begin
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (accept) begin
               col_top_d   = f1_dout;
               col_mid_d   = f0_dout;
               col_bot_d   = s_data;
               col_x_d     = cx_q;
               row_y_d     = ry_q;
               col_valid_d = 1'b1;
               cx_d        = cx_next;
               // The final pixel leaves ry parked on the last row so it never overflows its width.
               if (last_col && last_row) begin
                  state_d = ST_FLUSH;
               end else begin
                  ry_d = ry_next;
               end
            end
         end

         ST_FLUSH: begin
            if (f0_empty && f1_empty) begin
               frame_done_d = 1'b1;
               cx_d         = '0;
               ry_d         = '0;
               state_d      = ST_FILL0;
            end
         end

         default: begin
            state_d = ST_FILL0;
            cx_d    = '0;
            ry_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_FILL0;
         cx_q         <= '0;
         ry_q         <= '0;
         col_top_q    <= '0;
         col_mid_q    <= '0;
         col_bot_q    <= '0;
         col_x_q      <= '0;
         row_y_q      <= '0;
         col_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cx_q         <= cx_d;
         ry_q         <= ry_d;
         col_top_q    <= col_top_d;
         col_mid_q    <= col_mid_d;
         col_bot_q    <= col_bot_d;
         col_x_q      <= col_x_d;
         row_y_q      <= row_y_d;
         col_valid_q  <= col_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign col_top    = col_top_q;
   assign col_mid    = col_mid_q;
   assign col_bot    = col_bot_q;
   assign col_x      = col_x_q;
   assign row_y      = row_y_q;
   assign col_valid  = col_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl on a 4x3 image with two behavioural FWFT line FIFOs.
// Pixel value is 16*row + col, so every emitted column has a hand-known value.
module tb_line_buf_ctrl;

   localparam int WIDTH = 8;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int DEPTH = 8;

   logic             clk;
   logic             rst;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic             f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en;
   logic [WIDTH-1:0] f0_din, f0_dout, f1_din, f1_dout;
   logic             f0_empty, f0_full, f1_empty, f1_full;
   logic [WIDTH-1:0] col_top, col_mid, col_bot;
   logic             col_valid;
   logic [1:0]       col_x;
   logic [1:0]       row_y;
   logic             frame_done;

   logic             f1_force;

   int vec_cnt = 0;
   int err_cnt = 0;
   int fd_cnt  = 0;
   int cap_n   = 0;
   bit acc_pend = 1'b0;

   logic [WIDTH-1:0] cap_top [16];
   logic [WIDTH-1:0] cap_mid [16];
   logic [WIDTH-1:0] cap_bot [16];
   logic [1:0]       cap_x   [16];
   logic [1:0]       cap_y   [16];

   logic [WIDTH-1:0] exp_top [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
   logic [WIDTH-1:0] exp_mid [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
   logic [WIDTH-1:0] exp_bot [4] = '{8'h20, 8'h21, 8'h22, 8'h23};
   logic [1:0]       exp_x   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

   line_buf_ctrl #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .f0_wr_en   (f0_wr_en),
      .f0_din     (f0_din),
      .f0_rd_en   (f0_rd_en),
      .f0_dout    (f0_dout),
      .f0_empty   (f0_empty),
      .f0_full    (f0_full),
      .f1_wr_en   (f1_wr_en),
      .f1_din     (f1_din),
      .f1_rd_en   (f1_rd_en),
      .f1_dout    (f1_dout),
      .f1_empty   (f1_empty),
      .f1_full    (f1_full),
      .col_top    (col_top),
      .col_mid    (col_mid),
      .col_bot    (col_bot),
      .col_valid  (col_valid),
      .col_x      (col_x),
      .row_y      (row_y),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FWFT FIFOs, reset by the same active-low rst as the controller.
   logic [WIDTH-1:0] m0 [DEPTH];
   logic [WIDTH-1:0] m1 [DEPTH];
   logic [2:0]       w0, r0, w1, r1;
   logic [3:0]       n0, n1;
   logic             wr0_ok, rd0_ok, wr1_ok, rd1_ok, f1_empty_m;

   assign wr0_ok     = f0_wr_en && (n0 != 4'(DEPTH));
   assign rd0_ok     = f0_rd_en && (n0 != 4'd0);
   assign wr1_ok     = f1_wr_en && (n1 != 4'(DEPTH));
   assign rd1_ok     = f1_rd_en && (n1 != 4'd0);
   assign f0_dout    = m0[r0];
   assign f1_dout    = m1[r1];
   assign f0_empty   = (n0 == 4'd0);
   assign f0_full    = (n0 == 4'(DEPTH));
   assign f1_empty_m = (n1 == 4'd0);
   assign f1_empty   = f1_empty_m | f1_force;
   assign f1_full    = (n1 == 4'(DEPTH));

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         w0 <= '0; r0 <= '0; n0 <= '0;
         w1 <= '0; r1 <= '0; n1 <= '0;
      end else begin
         if (wr0_ok) begin m0[w0] <= f0_din; w0 <= w0 + 3'd1; end
         if (rd0_ok) r0 <= r0 + 3'd1;
         n0 <= n0 + 4'(wr0_ok) - 4'(rd0_ok);
         if (wr1_ok) begin m1[w1] <= f1_din; w1 <= w1 + 3'd1; end
         if (rd1_ok) r1 <= r1 + 3'd1;
         n1 <= n1 + 4'(wr1_ok) - 4'(rd1_ok);
      end
   end

   // Per-cycle monitor: column capture, column-follows-accept, and FIFO safety rules.
   always @(negedge clk) begin
      if (col_valid) begin
         vec_cnt++;
         if (acc_pend !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL col_valid_without_accept: col_valid=%b previous-edge accept=%b", col_valid, acc_pend);
         end
         if (cap_n < 16) begin
            cap_top[cap_n] = col_top;
            cap_mid[cap_n] = col_mid;
            cap_bot[cap_n] = col_bot;
            cap_x[cap_n]   = col_x;
            cap_y[cap_n]   = row_y;
         end
         cap_n++;
      end
      if (frame_done) fd_cnt++;
      #1;
      vec_cnt++;
      if ((f0_rd_en && f0_empty) || (f1_rd_en && f1_empty) ||
          (f0_wr_en && f0_full)  || (f1_wr_en && f1_full)  || (n0 > 4'(IMG_W))) begin
         err_cnt++;
         $display("[TB] FAIL fifo_safety: rd0=%b e0=%b rd1=%b e1=%b wr0=%b full0=%b wr1=%b full1=%b occ0=%0d (need no illegal access, occ0<=%0d)",
                  f0_rd_en, f0_empty, f1_rd_en, f1_empty, f0_wr_en, f0_full, f1_wr_en, f1_full, n0, IMG_W);
      end
      acc_pend = s_valid && s_ready && rst;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Offers one pixel until it is taken or the cycle budget runs out; returns aligned to a negedge.
   task automatic send_pixel(input logic [WIDTH-1:0] d, output bit ok);
      s_valid = 1'b1;
      s_data  = d;
      ok      = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         #1;
         if (s_ready) ok = 1'b1;
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic drive_frame(input int first, input int last, input bit gap);
      bit ok;
      for (int k = first; k < last; k++) begin
         send_pixel(8'(16 * (k / IMG_W) + (k % IMG_W)), ok);
         vec_cnt++;
         if (!ok) begin
            err_cnt++;
            $display("[TB] FAIL accept_timeout: pixel %0d not accepted, s_ready=%b", k, s_ready);
         end
         if (gap) @(negedge clk);
      end
   endtask

   task automatic wait_frame_done(output bit seen, output int ready_hi);
      seen     = 1'b0;
      ready_hi = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         #1;
         if (frame_done) seen = 1'b1;
         else if (s_ready) ready_hi++;
      end
   endtask

   task automatic test_reset;
      rst     = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hAA;
      #1;
      vec_cnt++;
      if ({s_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en} !== 5'b0) begin
         err_cnt++;
         $display("[TB] FAIL reset_handshake: ready/enables=%b, need 00000", {s_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en});
      end
      vec_cnt++;
      if ({col_top, col_mid, col_bot, col_x, row_y, col_valid, frame_done} !== '0) begin
         err_cnt++;
         $display("[TB] FAIL reset_outputs: top=%h mid=%h bot=%h x=%0d y=%0d v=%b fd=%b, need all 0",
                  col_top, col_mid, col_bot, col_x, row_y, col_valid, frame_done);
      end
      @(negedge clk);
      rst     = 1'b1;
      s_valid = 1'b0;
      #1;
      vec_cnt++;
      if (s_ready !== 1'b1) begin
         err_cnt++;
         $display("[TB] FAIL ready_after_reset: s_ready=%b, need 1", s_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_frame(input bit gap);
      bit seen;
      int hi;
      int fd0;
      cap_n = 0;
      fd0   = fd_cnt;
      drive_frame(0, IMG_W * IMG_H, gap);
      #1;
      vec_cnt++;
      if (s_ready !== 1'b0) begin
         err_cnt++;
         $display("[TB] FAIL flush_entry_ready: s_ready=%b after last pixel, need 0", s_ready);
      end
      wait_frame_done(seen, hi);
      vec_cnt++;
      if (!seen || hi != 0) begin
         err_cnt++;
         $display("[TB] FAIL flush_done: frame_done seen=%b, ready-high cycles=%0d, need 1 and 0", seen, hi);
      end
      vec_cnt++;
      if ({f0_empty, f1_empty} !== 2'b11) begin
         err_cnt++;
         $display("[TB] FAIL flush_empty: empties=%b, need 11", {f0_empty, f1_empty});
      end
      @(negedge clk);
      #1;
      vec_cnt++;
      if (frame_done !== 1'b0 || (fd_cnt - fd0) != 1) begin
         err_cnt++;
         $display("[TB] FAIL frame_done_pulse: frame_done=%b pulses=%0d, need 0 and 1", frame_done, fd_cnt - fd0);
      end
      vec_cnt++;
      if (cap_n != 4) begin
         err_cnt++;
         $display("[TB] FAIL column_count: got %0d columns, need 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if ({cap_top[i], cap_mid[i], cap_bot[i], cap_x[i], cap_y[i]} !== {exp_top[i], exp_mid[i], exp_bot[i], exp_x[i], 2'd2}) begin
            err_cnt++;
            $display("[TB] FAIL column_%0d: top=%h mid=%h bot=%h x=%0d y=%0d, need %h %h %h %0d 2",
                     i, cap_top[i], cap_mid[i], cap_bot[i], cap_x[i], cap_y[i], exp_top[i], exp_mid[i], exp_bot[i], exp_x[i]);
         end
      end
   endtask

   task automatic test_continuous;
      $display("[TB] continuous frame");
      test_frame(1'b0);
   endtask

   task automatic test_back_to_back;
      $display("[TB] back-to-back frame");
      test_frame(1'b0);
   endtask

   task automatic test_gapped;
      $display("[TB] gapped valid frame");
      test_frame(1'b1);
   endtask

   task automatic test_stall;
      bit seen;
      int hi;
      cap_n = 0;
      $display("[TB] f1_empty stall in RUN");
      drive_frame(0, 9, 1'b0);
      f1_force = 1'b1;
      s_valid  = 1'b1;
      s_data   = 8'h21;
      for (int c = 0; c < 3; c++) begin
         #1;
         vec_cnt++;
         if ({s_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en} !== 5'b0) begin
            err_cnt++;
            $display("[TB] FAIL stall_cycle_%0d: ready/enables=%b, need 00000", c, {s_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en});
         end
         @(negedge clk);
      end
      f1_force = 1'b0;
      drive_frame(9, IMG_W * IMG_H, 1'b0);
      wait_frame_done(seen, hi);
      vec_cnt++;
      if (!seen) begin
         err_cnt++;
         $display("[TB] FAIL stall_frame_done: frame_done seen=%b, need 1", seen);
      end
      @(negedge clk);
      vec_cnt++;
      if (cap_n != 4) begin
         err_cnt++;
         $display("[TB] FAIL stall_column_count: got %0d columns, need 4", cap_n);
      end
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if ({cap_top[i], cap_mid[i], cap_bot[i], cap_x[i], cap_y[i]} !== {exp_top[i], exp_mid[i], exp_bot[i], exp_x[i], 2'd2}) begin
            err_cnt++;
            $display("[TB] FAIL stall_column_%0d: top=%h mid=%h bot=%h x=%0d y=%0d, need %h %h %h %0d 2",
                     i, cap_top[i], cap_mid[i], cap_bot[i], cap_x[i], cap_y[i], exp_top[i], exp_mid[i], exp_bot[i], exp_x[i]);
         end
      end
   endtask

   task automatic test_mid_reset;
      int fd0;
      $display("[TB] reset after 6th pixel");
      fd0 = fd_cnt;
      drive_frame(0, 6, 1'b0);
      rst     = 1'b0;
      s_valid = 1'b1;
      #1;
      vec_cnt++;
      if ({col_top, col_mid, col_bot, col_x, row_y, col_valid, frame_done} !== '0) begin
         err_cnt++;
         $display("[TB] FAIL midreset_outputs: top=%h mid=%h bot=%h x=%0d y=%0d v=%b fd=%b, need all 0",
                  col_top, col_mid, col_bot, col_x, row_y, col_valid, frame_done);
      end
      vec_cnt++;
      if ({s_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en} !== 5'b0) begin
         err_cnt++;
         $display("[TB] FAIL midreset_handshake: ready/enables=%b, need 00000", {s_ready, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en});
      end
      @(negedge clk);
      s_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (fd_cnt != fd0) begin
         err_cnt++;
         $display("[TB] FAIL midreset_no_done: frame_done pulses=%0d, need 0", fd_cnt - fd0);
      end
      test_frame(1'b0);
   endtask

   initial begin
      rst      = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      f1_force = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      test_continuous;
      test_back_to_back;
      test_gapped;
      test_stall;
      test_mid_reset;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
